// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
// State encoding, parity modes, majority vote and config check.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic bit cfg_ok(
        input int db,
        input int par,
        input int sb,
        input int cpb
    );
        return (db >= 5) && (db <= 9) &&
               (par >= 0) && (par <= 2) &&
               (sb >= 1) && (sb <= 2) &&
               (cpb >= 8);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-word stream: valid/ready with data and parity status.
// The receiver drives the master side, the consumer the slave side.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;

    modport master (
        output valid,
        output data_out,
        output parity_err,
        input  ready
    );

    modport slave (
        input  valid,
        input  data_out,
        input  parity_err,
        output ready
    );
endinterface

// File: rtl/uart_bit_sampler.sv
// Synchroniser, falling-edge detect, bit timer and 3-sample vote.
// Timer value equals cycles elapsed since the aligned start edge.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    input  logic i_align,
    output logic o_line,
    output logic o_fall_edge,
    output logic o_bit_strobe,
    output logic o_bit_val
);
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [TW-1:0] r_timer;
    logic          r_s0;
    logic          r_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Loaded with 1 on the edge cycle so it counts cycles since the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (i_align) begin
            r_timer <= TW'(1);
        end else if (r_timer == TW'(CLKS_PER_BIT - 1)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_timer == TW'(MID - 1)) r_s0 <= r_sync2;
            if (r_timer == TW'(MID))     r_s1 <= r_sync2;
        end
    end

    assign o_line       = r_sync2;
    assign o_fall_edge  = r_prev & ~r_sync2;
    assign o_bit_strobe = (r_timer == TW'(MID + 1));
    assign o_bit_val    = maj3(r_s0, r_s1, r_sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// Frame-level UART receiver: FSM, shift register, parity, status
// pulses and the valid/ready output stage.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    uart_rx_frame_if.master  sif,
    output logic             frame_err,
    output logic             break_det,
    output logic             overrun
);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int HCW = $clog2(CLKS_PER_BIT);

    if (!cfg_ok(DATA_BITS, PARITY, STOP_BITS, CLKS_PER_BIT)) begin : g_cfg_bad
        $error("uart_rx_frame: parameter out of range");
    end

    uart_rx_state_e       r_state;
    uart_rx_state_e       w_next;
    logic [BCW-1:0]       r_bitcnt;
    logic                 r_stopcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_any_one;
    logic                 r_brk_wait;
    logic [HCW-1:0]       r_hi_cnt;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_ovr;

    logic w_line;
    logic w_fall;
    logic w_strobe;
    logic w_bit;
    logic w_align;
    logic w_shift;
    logic w_par_cap;
    logic w_stop_next;
    logic w_end_ok;
    logic w_end_bad;
    logic w_last_data;
    logic w_last_stop;
    logic w_is_break;
    logic w_load;
    logic w_accept;
    logic w_perr_calc;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (data_in),
        .i_align     (w_align),
        .o_line      (w_line),
        .o_fall_edge (w_fall),
        .o_bit_strobe(w_strobe),
        .o_bit_val   (w_bit)
    );

    assign w_last_data = (r_bitcnt == BCW'(DATA_BITS - 1));
    assign w_last_stop = (int'(r_stopcnt) == STOP_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_brk_wait) w_next = ST_START;
            end
            ST_START: begin
                if (w_strobe) w_next = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_strobe && w_last_data)
                    w_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_strobe) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_strobe && (!w_bit || w_last_stop)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_align     = 1'b0;
        w_shift     = 1'b0;
        w_par_cap   = 1'b0;
        w_stop_next = 1'b0;
        w_end_ok    = 1'b0;
        w_end_bad   = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_align   = w_fall && !r_brk_wait;
            ST_DATA:   w_shift   = w_strobe;
            ST_PARITY: w_par_cap = w_strobe;
            ST_STOP: begin
                w_stop_next = w_strobe && w_bit && !w_last_stop;
                w_end_ok    = w_strobe && w_bit && w_last_stop;
                w_end_bad   = w_strobe && !w_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_any_one <= 1'b0;
        end else begin
            if (w_align) begin
                r_bitcnt  <= '0;
                r_stopcnt <= 1'b0;
                r_par_bit <= 1'b0;
                r_any_one <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bitcnt  <= r_bitcnt + BCW'(1);
                r_any_one <= r_any_one | w_bit;
            end
            if (w_par_cap) begin
                r_par_bit <= w_bit;
                r_any_one <= r_any_one | w_bit;
            end
            if (w_stop_next) r_stopcnt <= 1'b1;
        end
    end

    // A break needs every bit low, including any earlier stop bit
    assign w_is_break  = !r_any_one && !r_stopcnt;
    assign w_perr_calc = (PARITY != PARITY_NONE) &&
                         (r_par_bit != ((^r_shift) ^ (PARITY == PARITY_ODD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ferr <= 1'b0;
            r_brk  <= 1'b0;
        end else begin
            r_ferr <= w_end_bad && !w_is_break;
            r_brk  <= w_end_bad && w_is_break;
        end
    end

    // After a break, edges are ignored until one full bit time of idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_wait <= 1'b0;
            r_hi_cnt   <= '0;
        end else if (w_end_bad && w_is_break) begin
            r_brk_wait <= 1'b1;
            r_hi_cnt   <= '0;
        end else if (r_brk_wait) begin
            if (!w_line) begin
                r_hi_cnt <= '0;
            end else if (r_hi_cnt == HCW'(CLKS_PER_BIT - 1)) begin
                r_brk_wait <= 1'b0;
                r_hi_cnt   <= '0;
            end else begin
                r_hi_cnt <= r_hi_cnt + HCW'(1);
            end
        end
    end

    assign w_accept = r_valid && sif.ready;
    assign w_load   = w_end_ok && (!r_valid || sif.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_end_ok && r_valid && !sif.ready;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
                r_perr  <= w_perr_calc;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sif.valid      = r_valid;
    assign sif.data_out   = r_data;
    assign sif.parity_err = r_perr;
    assign frame_err      = r_ferr;
    assign break_det      = r_brk;
    assign overrun        = r_ovr;

endmodule
